mem_cycle_arbiter: RTL and testbench
====================================

// Module: mem_cycle_arbiter
// PURPOSE
//  Shares the memory-module timing path between the CPU and NREQ data-adapter DMA requesters.
//  - Grants one memory cycle per SLOT strobe from the timing section.
//  - Muxes the winning address.
//  - Times the cycle and returns a one-clock ACK (or ERR) to the winner.
//  - Sits between the timing/transfer-register logic and mem_timing, and drives the DMA/CPU cycle selects.
// PARAMETERS
//  NREQ     2   number of DMA requesters (1..4)
//  ADDR_W   13  memory address width (syllable/sector/word)
//  CYC_LEN  8   clocks per memory cycle, GO to ACK (>=3)
//  MAX_RUN  3   consecutive DMA grants allowed while CPU_REQ is pending (>=1)
// PORTS
//  CLK       in   1              system clock
//  RESETN    in   1              async active-low reset
//  SLOT      in   1              1-clk strobe: a memory cycle slot opens
//  HALTV     in   1              computer halted; CPU requests are not granted
//  CPU_REQ   in   1              CPU requests a cycle (level, held until ACK/ERR)
//  CPU_ADDR  in   ADDR_W         CPU address, stable while CPU_REQ is high
//  DMA_REQ   in   NREQ           DMA request per requester (level)
//  DMA_ADDR  in   NREQ*ADDR_W    packed DMA addresses, requester i at [i*ADDR_W +: ADDR_W]
//  TER       in   1              memory error flag from mem_timing, sampled during BUSY
//  MEM_GO    out  1              1-clk pulse starting a cycle
//  MEM_ADDR  out  ADDR_W         registered address, held from GO to end of cycle
//  MEM_DMA   out  1              current cycle is a DMA cycle
//  MEM_SEL   out  2              DMA requester index of current cycle (0 for CPU)
//  BUSY      out  1              a cycle is in progress
//  CPU_ACK   out  1              1-clk: CPU cycle completed
//  DMA_ACK   out  NREQ           1-clk: DMA cycle i completed
//  ERR       out  1              1-clk, coincident with ACK: TER seen during that cycle
//  MISSED    out  1              1-clk: SLOT arrived while BUSY, and the slot is lost
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; run counter = 0; error latch = 0. Reset mid-cycle aborts the cycle and issues no ACK.
//  FSM states:
//   - IDLE --SLOT & any eligible request--> GO. Requests are sampled in the same clock as SLOT.
//   - GO, 1 clk: MEM_GO=1; MEM_ADDR, MEM_DMA and MEM_SEL load; BUSY=1. -> BUSY.
//   - BUSY: the counter runs CYC_LEN-1 clocks, then -> DONE.
//   - DONE, 1 clk: ACK for the winner; ERR if TER was seen; BUSY=0. -> IDLE.
//  Eligibility: a DMA requester is eligible while its DMA_REQ is high; the CPU is eligible while CPU_REQ & ~HALTV.
//  Priority: DMA beats CPU; the lowest DMA index wins. Exception: if run counter == MAX_RUN and the CPU is eligible, the CPU wins.
//  Run counter:
//   - increments on a DMA grant while the CPU is eligible;
//   - clears on a CPU grant or when the CPU is not eligible;
//   - saturates at MAX_RUN.
//  SLOT while in GO/BUSY/DONE: pulse MISSED; no queueing.
//  SLOT in IDLE with no eligible request: nothing happens.
//  Requester drops REQ mid-cycle: the cycle completes and ACK is still pulsed.
//  HALTV rising mid-CPU-cycle: the cycle completes normally.
//  TER is latched during BUSY and cleared at DONE.
//  Latency: SLOT -> MEM_GO is 1 clk; MEM_GO -> ACK is CYC_LEN clks.
// CONFIGURATION
//  LVDC_ARB_STATS_EN defined:
//   - adds outputs STAT_CPU[15:0], STAT_DMA[15:0] and STAT_MISS[15:0];
//   - these are saturating counts of CPU grants, DMA grants and missed slots;
//   - they clear on reset.
//  LVDC_ARB_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Package lvdc_arb_pkg:
//   - FSM state enum (IDLE, GO, BUSY, DONE);
//   - SEL_W=2 constant;
//   - function for the lowest-set-bit index.
//  Sub-module arb_pick: combinational priority select (DMA fixed priority plus CPU fairness override). Outputs winner index, winner-is-CPU flag and valid.
// TESTING
//  1. CPU_REQ=1, CPU_ADDR=0x0A5, one SLOT -> MEM_GO next clk, MEM_ADDR=0x0A5, MEM_DMA=0, CPU_ACK 8 clks after GO.
//  2. DMA_REQ=2'b11 and CPU_REQ=1 held, 5 SLOTs -> grant order DMA0, DMA0, DMA0, CPU, DMA0.
//  3. SLOT pulsed 3 clks after GO -> MISSED=1 for 1 clk; no second GO until the next SLOT after DONE.
//  4. HALTV=1, CPU_REQ=1, DMA_REQ=0, SLOT -> no MEM_GO. Then HALTV=0 and next SLOT -> CPU cycle runs.
//  5. TER=1 for 1 clk during a DMA1 cycle -> DMA_ACK=2'b10 and ERR=1 together; next cycle has ERR=0.
//  6. RESETN low 2 clks mid-BUSY -> all outputs 0 immediately, no ACK; the next SLOT starts a fresh cycle.

Source files
------------

// File: rtl/lvdc_arb_pkg.sv
// Shared types and helpers for the memory cycle arbiter: FSM state encoding,
// select width and a lowest-set-bit picker.
package lvdc_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGo,
        StBusy,
        StDone
    } arb_state_e;

    localparam int unsigned SEL_W = 2;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [3:0] vec);
        lowest_set = '0;
        for (int i = 3; i >= 0; i--) begin
            if (vec[i]) begin
                lowest_set = SEL_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select: fixed-priority DMA (lowest index first) with a CPU
// override once the DMA run counter has reached its limit.
module arb_pick
    import lvdc_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned RUN_W   = 2,
    parameter int unsigned MAX_RUN = 3
) (
    input  logic [NREQ-1:0]  dma_req,
    input  logic             cpu_elig,
    input  logic [RUN_W-1:0] run_cnt,
    output logic [SEL_W-1:0] win_idx,
    output logic             win_cpu,
    output logic             valid
);

    logic [3:0] req_ext;
    logic       any_dma;
    logic       cpu_turn;

    always_comb begin
        req_ext = '0;
        req_ext[NREQ-1:0] = dma_req;
    end

    assign any_dma  = |dma_req;
    assign cpu_turn = cpu_elig && (!any_dma || (run_cnt == RUN_W'(MAX_RUN)));

    assign win_cpu  = cpu_turn;
    assign win_idx  = cpu_turn ? '0 : lowest_set(req_ext);
    assign valid    = any_dma || cpu_elig;

endmodule

// File: rtl/mem_cycle_arbiter.sv
// Grants one memory cycle per slot strobe to the CPU or a DMA requester, times it and
// returns ack/err. Define LVDC_ARB_STATS_EN to add grant/miss statistics counters.
module mem_cycle_arbiter
    import lvdc_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned CYC_LEN = 8,
    parameter int unsigned MAX_RUN = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   slot,
    input  logic                   haltv,
    input  logic                   cpu_req,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [NREQ-1:0]        dma_req,
    input  logic [NREQ*ADDR_W-1:0] dma_addr,
    input  logic                   ter,
    output logic                   mem_go,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_dma,
    output logic [SEL_W-1:0]       mem_sel,
    output logic                   busy,
    output logic                   cpu_ack,
    output logic [NREQ-1:0]        dma_ack,
    output logic                   err,
    output logic                   missed
`ifdef LVDC_ARB_STATS_EN
    ,
    output logic [15:0]            stat_cpu,
    output logic [15:0]            stat_dma,
    output logic [15:0]            stat_miss
`endif
);

    localparam int unsigned CNT_W = $clog2(CYC_LEN);
    localparam int unsigned RUN_W = $clog2(MAX_RUN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYC_LEN - 2);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_RUN);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q;
    logic              dma_q;
    logic [SEL_W-1:0]  sel_q;

    logic              cpu_elig;
    logic              grant;
    logic [SEL_W-1:0]  win_idx;
    logic              win_cpu;
    logic              win_valid;
    logic [ADDR_W-1:0] win_addr;

    assign cpu_elig = cpu_req && !haltv;
    assign grant    = (state_q == StIdle) && slot && win_valid;

    arb_pick #(
        .NREQ    (NREQ),
        .RUN_W   (RUN_W),
        .MAX_RUN (MAX_RUN)
    ) u_pick (
        .dma_req  (dma_req),
        .cpu_elig (cpu_elig),
        .run_cnt  (run_q),
        .win_idx  (win_idx),
        .win_cpu  (win_cpu),
        .valid    (win_valid)
    );

    always_comb begin
        win_addr = cpu_addr;
        if (!win_cpu) begin
            for (int i = 0; i < NREQ; i++) begin
                if (win_idx == SEL_W'(i)) begin
                    win_addr = dma_addr[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    // Fairness run: only counts DMA wins that made an eligible CPU wait.
    always_comb begin
        run_d = run_q;
        if (!cpu_elig) begin
            run_d = '0;
        end else if (grant) begin
            if (win_cpu) begin
                run_d = '0;
            end else if (run_q != RUN_MAX) begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StGo;
                end
            end
            StGo: begin
                state_d = StBusy;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            StBusy: begin
                err_d = err_q || ter;
                if (cnt_q == CNT_LAST) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                err_d   = 1'b0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            run_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            dma_q   <= 1'b0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            err_q   <= err_d;
            if (grant) begin
                addr_q <= win_addr;
                dma_q  <= !win_cpu;
                sel_q  <= win_idx;
            end
        end
    end

    assign mem_go   = (state_q == StGo);
    assign busy     = (state_q == StGo) || (state_q == StBusy);
    assign missed   = slot && (state_q != StIdle);
    assign cpu_ack  = (state_q == StDone) && !dma_q;
    assign err      = (state_q == StDone) && err_q;
    assign mem_addr = addr_q;
    assign mem_dma  = dma_q;
    assign mem_sel  = sel_q;

    always_comb begin
        dma_ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            dma_ack[i] = (state_q == StDone) && dma_q && (sel_q == SEL_W'(i));
        end
    end

`ifdef LVDC_ARB_STATS_EN
    logic [15:0] stat_cpu_q, stat_dma_q, stat_miss_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_cpu_q  <= '0;
            stat_dma_q  <= '0;
            stat_miss_q <= '0;
        end else begin
            if (grant && win_cpu && (stat_cpu_q != 16'hFFFF)) begin
                stat_cpu_q <= stat_cpu_q + 16'd1;
            end
            if (grant && !win_cpu && (stat_dma_q != 16'hFFFF)) begin
                stat_dma_q <= stat_dma_q + 16'd1;
            end
            if (missed && (stat_miss_q != 16'hFFFF)) begin
                stat_miss_q <= stat_miss_q + 16'd1;
            end
        end
    end

    assign stat_cpu  = stat_cpu_q;
    assign stat_dma  = stat_dma_q;
    assign stat_miss = stat_miss_q;
`endif

endmodule

// File: tb/tb_mem_cycle_arbiter.sv
// Self-checking bench for mem_cycle_arbiter: directed vector table, hand-written corner
// sequences and a randomized phase against a timer-based reference model.
module tb_mem_cycle_arbiter;

    localparam int unsigned NREQ    = 2;
    localparam int unsigned ADDR_W  = 13;
    localparam int unsigned CYC_LEN = 8;
    localparam int unsigned MAX_RUN = 3;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic                   slot;
    logic                   haltv;
    logic                   cpu_req;
    logic [ADDR_W-1:0]      cpu_addr;
    logic [NREQ-1:0]        dma_req;
    logic [NREQ*ADDR_W-1:0] dma_addr;
    logic                   ter;
    logic                   mem_go;
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_dma;
    logic [1:0]             mem_sel;
    logic                   busy;
    logic                   cpu_ack;
    logic [NREQ-1:0]        dma_ack;
    logic                   err;
    logic                   missed;
`ifdef LVDC_ARB_STATS_EN
    logic [15:0]            stat_cpu;
    logic [15:0]            stat_dma;
    logic [15:0]            stat_miss;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_cycle_arbiter #(
        .NREQ    (NREQ),
        .ADDR_W  (ADDR_W),
        .CYC_LEN (CYC_LEN),
        .MAX_RUN (MAX_RUN)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .slot     (slot),
        .haltv    (haltv),
        .cpu_req  (cpu_req),
        .cpu_addr (cpu_addr),
        .dma_req  (dma_req),
        .dma_addr (dma_addr),
        .ter      (ter),
        .mem_go   (mem_go),
        .mem_addr (mem_addr),
        .mem_dma  (mem_dma),
        .mem_sel  (mem_sel),
        .busy     (busy),
        .cpu_ack  (cpu_ack),
        .dma_ack  (dma_ack),
        .err      (err),
        .missed   (missed)
`ifdef LVDC_ARB_STATS_EN
        ,
        .stat_cpu  (stat_cpu),
        .stat_dma  (stat_dma),
        .stat_miss (stat_miss)
`endif
    );

    typedef struct {
        logic       cpu_req;
        logic       haltv;
        logic [1:0] dma;
        logic       exp_go;
        logic       exp_dma;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses one slot and, if a cycle starts, follows it to its ack and back to idle.
    task automatic run_slot(input bit ter_pulse, output logic go_s, output logic dma_s,
                            output logic [1:0] sel_s, output logic [ADDR_W-1:0] addr_s,
                            output logic cack, output logic [NREQ-1:0] dack,
                            output logic e, output int lat);
        slot = 1'b1;
        tick();
        slot   = 1'b0;
        go_s   = mem_go;
        dma_s  = mem_dma;
        sel_s  = mem_sel;
        addr_s = mem_addr;
        lat    = 0;
        cack   = 1'b0;
        dack   = '0;
        e      = 1'b0;
        if (go_s) begin
            while (!(cpu_ack || (|dma_ack)) && lat < 20) begin
                ter = ter_pulse && (lat == 2);
                tick();
                lat++;
            end
            ter  = 1'b0;
            cack = cpu_ack;
            dack = dma_ack;
            e    = err;
            tick();
        end
    endtask

    function automatic logic [31:0] outs_packed();
        return 32'({mem_go, mem_addr, mem_dma, mem_sel, busy, cpu_ack, dma_ack, err, missed});
    endfunction

    // Reference model: an active cycle is tracked by its age in clocks since GO.
    bit               m_active;
    int               m_age;
    bit               m_cpu;
    int               m_idx;
    bit               m_err;
    int               m_run;
    logic [ADDR_W-1:0] m_addr;

    task automatic model_step();
        bit cpu_el;
        bit granted;
        bit pick_cpu;
        int pick;
        cpu_el  = cpu_req && !haltv;
        granted = 1'b0;
        pick_cpu = 1'b0;
        if (m_active) begin
            if (m_age >= 1 && m_age < int'(CYC_LEN) && ter) m_err = 1'b1;
            if (m_age == int'(CYC_LEN)) m_active = 1'b0;
            else m_age++;
        end else if (slot && (cpu_el || dma_req != '0)) begin
            pick = 0;
            for (int i = int'(NREQ) - 1; i >= 0; i--) if (dma_req[i]) pick = i;
            pick_cpu = (dma_req == '0) || (cpu_el && m_run == int'(MAX_RUN));
            granted  = 1'b1;
            m_active = 1'b1;
            m_age    = 0;
            m_err    = 1'b0;
            m_cpu    = pick_cpu;
            m_idx    = pick_cpu ? 0 : pick;
            m_addr   = pick_cpu ? cpu_addr : dma_addr[pick*ADDR_W +: ADDR_W];
        end
        if (!cpu_el) m_run = 0;
        else if (granted) m_run = pick_cpu ? 0 : ((m_run < int'(MAX_RUN)) ? m_run + 1 : m_run);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic              go_s, dma_s, cack, e, acc;
        logic [1:0]        sel_s;
        logic [ADDR_W-1:0] addr_s;
        logic [NREQ-1:0]   dack;
        logic [ADDR_W-1:0] exp_addr;
        logic [6:0]        exp_ctl;
        bit                e_done;
        int                lat;
        int                gos;

        tbl[0] = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 2'd0};
        tbl[1] = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 2'd0};
        tbl[2] = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 2'd0};
        tbl[3] = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 2'd0};
        tbl[4] = '{1'b1, 1'b0, 2'b11, 1'b1, 1'b1, 2'd0};
        tbl[5] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'd0};
        tbl[6] = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'd0};
        tbl[7] = '{1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 2'd1};
        tbl[8] = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 2'd0};

        resetn = 1'b0; slot = 1'b0; haltv = 1'b0; cpu_req = 1'b0;
        cpu_addr = '0; dma_req = '0; dma_addr = '0; ter = 1'b0;
        tick();
        tick();
        check("reset outputs", outs_packed(), 32'd0);
        resetn = 1'b1;
        tick();

        // Single CPU cycle
        cpu_req = 1'b1; cpu_addr = 13'h0A5;
        run_slot(1'b0, go_s, dma_s, sel_s, addr_s, cack, dack, e, lat);
        check("t1 go", 32'(go_s), 32'd1);
        check("t1 addr", 32'(addr_s), 32'h0A5);
        check("t1 dma", 32'(dma_s), 32'd0);
        check("t1 latency", 32'(lat), 32'(CYC_LEN));
        check("t1 cpu_ack", 32'(cack), 32'd1);
        cpu_req = 1'b0;
        tick();

        // Arbitration table
        for (int i = 0; i < 9; i++) begin
            cpu_req  = tbl[i].cpu_req;
            haltv    = tbl[i].haltv;
            dma_req  = tbl[i].dma;
            cpu_addr = ADDR_W'(13'h100 + i);
            dma_addr = {ADDR_W'(13'h300 + i), ADDR_W'(13'h200 + i)};
            run_slot(1'b0, go_s, dma_s, sel_s, addr_s, cack, dack, e, lat);
            check($sformatf("tbl%0d go", i), 32'(go_s), 32'(tbl[i].exp_go));
            if (tbl[i].exp_go) begin
                exp_addr = tbl[i].exp_dma ? ADDR_W'((tbl[i].exp_sel != 0 ? 13'h300 : 13'h200) + i)
                                          : ADDR_W'(13'h100 + i);
                check($sformatf("tbl%0d dma", i), 32'(dma_s), 32'(tbl[i].exp_dma));
                check($sformatf("tbl%0d sel", i), 32'(sel_s), 32'(tbl[i].exp_sel));
                check($sformatf("tbl%0d addr", i), 32'(addr_s), 32'(exp_addr));
                check($sformatf("tbl%0d latency", i), 32'(lat), 32'(CYC_LEN));
                check($sformatf("tbl%0d ack", i), 32'({cack, dack}),
                      tbl[i].exp_dma ? 32'(2'b01 << tbl[i].exp_sel) : 32'h4);
            end
        end
        cpu_req = 1'b0; haltv = 1'b0; dma_req = '0;
        tick();

        // Slot during an active cycle is lost
        dma_req = 2'b01;
        slot = 1'b1;
        tick();
        slot = 1'b0;
        check("t3 go", 32'(mem_go), 32'd1);
        tick(); tick(); tick();
        slot = 1'b1;
        #1;
        check("t3 missed", 32'(missed), 32'd1);
        tick();
        slot = 1'b0;
        #1;
        check("t3 missed one clk", 32'(missed), 32'd0);
        gos = 0; lat = 0;
        while (!dma_ack[0] && lat < 20) begin
            if (mem_go) gos++;
            tick();
            lat++;
        end
        check("t3 ack seen", 32'(dma_ack), 32'd1);
        check("t3 no extra go", 32'(gos), 32'd0);
        tick(); tick();
        check("t3 idle without slot", 32'({mem_go, busy}), 32'd0);
        run_slot(1'b0, go_s, dma_s, sel_s, addr_s, cack, dack, e, lat);
        check("t3 next slot go", 32'(go_s), 32'd1);
        dma_req = '0;

        // Error flag on a DMA1 cycle, then clean cycle
        dma_req = 2'b10;
        run_slot(1'b1, go_s, dma_s, sel_s, addr_s, cack, dack, e, lat);
        check("t5 ack", 32'(dack), 32'b10);
        check("t5 err", 32'(e), 32'd1);
        run_slot(1'b0, go_s, dma_s, sel_s, addr_s, cack, dack, e, lat);
        check("t5 ack2", 32'(dack), 32'b10);
        check("t5 err cleared", 32'(e), 32'd0);

        // Reset mid-cycle aborts without ack
        dma_req = 2'b01;
        slot = 1'b1;
        tick();
        slot = 1'b0;
        tick(); tick(); tick();
        check("t6 busy before reset", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("t6 outputs in reset", outs_packed(), 32'd0);
        acc = 1'b0;
        tick(); acc = acc | cpu_ack | (|dma_ack);
        tick(); acc = acc | cpu_ack | (|dma_ack);
        check("t6 no ack", 32'(acc), 32'd0);
        resetn = 1'b1;
        tick();
        run_slot(1'b0, go_s, dma_s, sel_s, addr_s, cack, dack, e, lat);
        check("t6 fresh go", 32'(go_s), 32'd1);
        check("t6 fresh latency", 32'(lat), 32'(CYC_LEN));
        check("t6 fresh ack", 32'(dack), 32'b01);

        // Randomized phase against the reference model
        resetn = 1'b0; slot = 1'b0; dma_req = '0; cpu_req = 1'b0; haltv = 1'b0;
        tick();
        resetn = 1'b1;
        m_active = 1'b0; m_age = 0; m_cpu = 1'b0; m_idx = 0; m_err = 1'b0; m_run = 0;
        m_addr = '0;
        for (int c = 0; c < 800; c++) begin
            slot     = ($urandom_range(0, 3) == 0);
            cpu_req  = $urandom_range(0, 1) != 0;
            haltv    = ($urandom_range(0, 7) == 0);
            dma_req  = NREQ'($urandom_range(0, 3));
            ter      = ($urandom_range(0, 5) == 0);
            cpu_addr = ADDR_W'($urandom);
            dma_addr = {ADDR_W'($urandom), ADDR_W'($urandom)};
            @(negedge clk);
            e_done  = m_active && (m_age == int'(CYC_LEN));
            exp_ctl = {m_active && (m_age == 0), m_active && (m_age < int'(CYC_LEN)),
                       e_done && m_cpu,
                       (e_done && !m_cpu) ? NREQ'(1 << m_idx) : NREQ'(0),
                       e_done && m_err, slot && m_active};
            check($sformatf("rand ctl c=%0d", c),
                  32'({mem_go, busy, cpu_ack, dma_ack, err, missed}), 32'(exp_ctl));
            if (m_active) begin
                check($sformatf("rand dp c=%0d", c), 32'({mem_addr, mem_dma, mem_sel}),
                      32'({m_addr, !m_cpu, 2'(m_idx)}));
            end
            @(posedge clk);
            model_step();
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
